// File: rtl/id_ex_dual_reg_if.sv
// rtl/id_ex_dual_reg_if.sv - decode/execute bundle for the dual-issue ID/EX register
// SplitCount_o exists only when ID_EX_SPLIT_CNT_EN is defined.
interface id_ex_dual_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // decode side and hazard-unit controls
  logic                      InValid_i;
  logic                      InReady_o;
  logic                      Stall_i;
  logic                      Flush_i;
  logic                      ValidA_i;
  logic                      ValidB_i;
  logic [3:0]                ALUCtrlA_i;
  logic [3:0]                ALUCtrlB_i;
  logic                      ALUSrcBA_i;
  logic                      ALUSrcBB_i;
  logic [DATA_WIDTH-1:0]     RD1A_i;
  logic [DATA_WIDTH-1:0]     RD2A_i;
  logic [DATA_WIDTH-1:0]     RD1B_i;
  logic [DATA_WIDTH-1:0]     RD2B_i;
  logic [DATA_WIDTH-1:0]     ImmExtA_i;
  logic [DATA_WIDTH-1:0]     ImmExtB_i;
  logic [REG_ADDR_WIDTH-1:0] Rs1B_i;
  logic [REG_ADDR_WIDTH-1:0] Rs2B_i;
  logic [REG_ADDR_WIDTH-1:0] RdA_i;
  logic [REG_ADDR_WIDTH-1:0] RdB_i;
  logic                      RegWriteA_i;
  logic                      RegWriteB_i;
  logic [DATA_WIDTH-1:0]     ALUResultA_i;

  // execute side
  logic                      ValidA_o;
  logic                      ValidB_o;
  logic [3:0]                ALUCtrlA_o;
  logic [3:0]                ALUCtrlB_o;
  logic                      ALUSrcBA_o;
  logic                      ALUSrcBB_o;
  logic [DATA_WIDTH-1:0]     RD1A_o;
  logic [DATA_WIDTH-1:0]     RD2A_o;
  logic [DATA_WIDTH-1:0]     RD1B_o;
  logic [DATA_WIDTH-1:0]     RD2B_o;
  logic [DATA_WIDTH-1:0]     ImmExtA_o;
  logic [DATA_WIDTH-1:0]     ImmExtB_o;
  logic [REG_ADDR_WIDTH-1:0] RdA_o;
  logic [REG_ADDR_WIDTH-1:0] RdB_o;
  logic                      RegWriteA_o;
  logic                      RegWriteB_o;
`ifdef ID_EX_SPLIT_CNT_EN
  logic [31:0]               SplitCount_o;
`endif

  modport master (
    output InValid_i, Stall_i, Flush_i, ValidA_i, ValidB_i,
           ALUCtrlA_i, ALUCtrlB_i, ALUSrcBA_i, ALUSrcBB_i,
           RD1A_i, RD2A_i, RD1B_i, RD2B_i, ImmExtA_i, ImmExtB_i,
           Rs1B_i, Rs2B_i, RdA_i, RdB_i, RegWriteA_i, RegWriteB_i, ALUResultA_i,
    input  InReady_o, ValidA_o, ValidB_o, ALUCtrlA_o, ALUCtrlB_o,
           ALUSrcBA_o, ALUSrcBB_o, RD1A_o, RD2A_o, RD1B_o, RD2B_o,
           ImmExtA_o, ImmExtB_o, RdA_o, RdB_o, RegWriteA_o, RegWriteB_o
`ifdef ID_EX_SPLIT_CNT_EN
    , input SplitCount_o
`endif
  );

  modport slave (
    input  InValid_i, Stall_i, Flush_i, ValidA_i, ValidB_i,
           ALUCtrlA_i, ALUCtrlB_i, ALUSrcBA_i, ALUSrcBB_i,
           RD1A_i, RD2A_i, RD1B_i, RD2B_i, ImmExtA_i, ImmExtB_i,
           Rs1B_i, Rs2B_i, RdA_i, RdB_i, RegWriteA_i, RegWriteB_i, ALUResultA_i,
    output InReady_o, ValidA_o, ValidB_o, ALUCtrlA_o, ALUCtrlB_o,
           ALUSrcBA_o, ALUSrcBB_o, RD1A_o, RD2A_o, RD1B_o, RD2B_o,
           ImmExtA_o, ImmExtB_o, RdA_o, RdB_o, RegWriteA_o, RegWriteB_o
`ifdef ID_EX_SPLIT_CNT_EN
    , output SplitCount_o
`endif
  );
endinterface

// File: rtl/id_ex_dual_reg.sv
// rtl/id_ex_dual_reg.sv - dual-issue ID/EX register with intra-pair RAW split
// Optional split counter enabled by ID_EX_SPLIT_CNT_EN.
module id_ex_dual_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic             clk,
  input logic             rst_n,
  id_ex_dual_reg_if.slave bus
);

  typedef enum logic {NORMAL, SPLIT} state_t;

  state_t state;
  logic   fwd1;
  logic   fwd2;
  logic   hazard;
  logic   accept;

  // slot-B instruction parked while slot A runs ahead alone
  logic [3:0]                h_ctrl;
  logic                      h_srcb;
  logic [DATA_WIDTH-1:0]     h_rd1;
  logic [DATA_WIDTH-1:0]     h_rd2;
  logic [DATA_WIDTH-1:0]     h_imm;
  logic [REG_ADDR_WIDTH-1:0] h_rd;
  logic                      h_rw;
  logic                      h_fwd1;
  logic                      h_fwd2;

  // B depends on A when it reads a register A is about to write (x0 excluded)
  always_comb begin
    fwd1   = (bus.Rs1B_i == bus.RdA_i);
    fwd2   = !bus.ALUSrcBB_i && (bus.Rs2B_i == bus.RdA_i);
    hazard = bus.ValidA_i && bus.ValidB_i && bus.RegWriteA_i &&
             (bus.RdA_i != '0) && (fwd1 || fwd2);
  end

  assign bus.InReady_o = rst_n && !bus.Stall_i && (state == NORMAL);
  assign accept        = bus.InValid_i && bus.InReady_o;

  // pipeline register and NORMAL/SPLIT sequencing; flush beats stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= NORMAL;
      bus.ValidA_o    <= 1'b0;
      bus.ValidB_o    <= 1'b0;
      bus.ALUCtrlA_o  <= '0;
      bus.ALUCtrlB_o  <= '0;
      bus.ALUSrcBA_o  <= 1'b0;
      bus.ALUSrcBB_o  <= 1'b0;
      bus.RD1A_o      <= '0;
      bus.RD2A_o      <= '0;
      bus.RD1B_o      <= '0;
      bus.RD2B_o      <= '0;
      bus.ImmExtA_o   <= '0;
      bus.ImmExtB_o   <= '0;
      bus.RdA_o       <= '0;
      bus.RdB_o       <= '0;
      bus.RegWriteA_o <= 1'b0;
      bus.RegWriteB_o <= 1'b0;
      h_ctrl          <= '0;
      h_srcb          <= 1'b0;
      h_rd1           <= '0;
      h_rd2           <= '0;
      h_imm           <= '0;
      h_rd            <= '0;
      h_rw            <= 1'b0;
      h_fwd1          <= 1'b0;
      h_fwd2          <= 1'b0;
    end else if (bus.Flush_i) begin
      state           <= NORMAL;
      bus.ValidA_o    <= 1'b0;
      bus.ValidB_o    <= 1'b0;
      bus.RegWriteA_o <= 1'b0;
      bus.RegWriteB_o <= 1'b0;
      h_ctrl          <= '0;
      h_srcb          <= 1'b0;
      h_rd1           <= '0;
      h_rd2           <= '0;
      h_imm           <= '0;
      h_rd            <= '0;
      h_rw            <= 1'b0;
      h_fwd1          <= 1'b0;
      h_fwd2          <= 1'b0;
    end else if (!bus.Stall_i) begin
      if (state == SPLIT) begin
        // A slot idles; the parked B picks up A's result from execute
        state           <= NORMAL;
        bus.ValidA_o    <= 1'b0;
        bus.RegWriteA_o <= 1'b0;
        bus.ValidB_o    <= 1'b1;
        bus.ALUCtrlB_o  <= h_ctrl;
        bus.ALUSrcBB_o  <= h_srcb;
        bus.RD1B_o      <= h_fwd1 ? bus.ALUResultA_i : h_rd1;
        bus.RD2B_o      <= h_fwd2 ? bus.ALUResultA_i : h_rd2;
        bus.ImmExtB_o   <= h_imm;
        bus.RdB_o       <= h_rd;
        bus.RegWriteB_o <= h_rw;
      end else if (accept) begin
        bus.ValidA_o    <= bus.ValidA_i;
        bus.ALUCtrlA_o  <= bus.ALUCtrlA_i;
        bus.ALUSrcBA_o  <= bus.ALUSrcBA_i;
        bus.RD1A_o      <= bus.RD1A_i;
        bus.RD2A_o      <= bus.RD2A_i;
        bus.ImmExtA_o   <= bus.ImmExtA_i;
        bus.RdA_o       <= bus.RdA_i;
        bus.RegWriteA_o <= bus.RegWriteA_i;
        if (hazard) begin
          state           <= SPLIT;
          bus.ValidB_o    <= 1'b0;
          bus.ALUCtrlB_o  <= '0;
          bus.ALUSrcBB_o  <= 1'b0;
          bus.RD1B_o      <= '0;
          bus.RD2B_o      <= '0;
          bus.ImmExtB_o   <= '0;
          bus.RdB_o       <= '0;
          bus.RegWriteB_o <= 1'b0;
          h_ctrl          <= bus.ALUCtrlB_i;
          h_srcb          <= bus.ALUSrcBB_i;
          h_rd1           <= bus.RD1B_i;
          h_rd2           <= bus.RD2B_i;
          h_imm           <= bus.ImmExtB_i;
          h_rd            <= bus.RdB_i;
          h_rw            <= bus.RegWriteB_i;
          h_fwd1          <= fwd1;
          h_fwd2          <= fwd2;
        end else begin
          bus.ValidB_o    <= bus.ValidB_i;
          bus.ALUCtrlB_o  <= bus.ALUCtrlB_i;
          bus.ALUSrcBB_o  <= bus.ALUSrcBB_i;
          bus.RD1B_o      <= bus.RD1B_i;
          bus.RD2B_o      <= bus.RD2B_i;
          bus.ImmExtB_o   <= bus.ImmExtB_i;
          bus.RdB_o       <= bus.RdB_i;
          bus.RegWriteB_o <= bus.RegWriteB_i;
        end
      end else begin
        // bubble: data fields keep their last values, nothing is live
        bus.ValidA_o    <= 1'b0;
        bus.ValidB_o    <= 1'b0;
        bus.RegWriteA_o <= 1'b0;
        bus.RegWriteB_o <= 1'b0;
      end
    end
  end

`ifdef ID_EX_SPLIT_CNT_EN
  logic [31:0] split_cnt;

  // count pairs that had to be split; free-running, ignores flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_cnt <= '0;
    end else if (!bus.Flush_i && accept && hazard) begin
      split_cnt <= split_cnt + 32'd1;
    end
  end

  assign bus.SplitCount_o = split_cnt;
`endif

endmodule

// File: tb/tb_id_ex_dual_reg.sv
// tb/tb_id_ex_dual_reg.sv - scoreboard bench for id_ex_dual_reg
module tb_id_ex_dual_reg;

  logic clk;
  logic rst_n;

  id_ex_dual_reg_if bus ();

  id_ex_dual_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        in_valid, stall, flush, va, vb, srca, srcb, rwa, rwb;
    logic [3:0]  ca, cb;
    logic [31:0] rd1a, rd2a, rd1b, rd2b, imma, immb, alu;
    logic [4:0]  rs1b, rs2b, rda, rdb;
  } stim_t;

  typedef struct packed {
    logic        va, vb, rwa, rwb, srca, srcb, chk_a, chk_b;
    logic [3:0]  ca, cb;
    logic [31:0] rd1a, rd2a, rd1b, rd2b, imma, immb, splits;
    logic [4:0]  rda, rdb;
  } exp_t;

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  exp_q[$];
  stim_t parked_q[$];   // dependent B instructions waiting for their A result
  exp_t  cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  function automatic stim_t blank();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.in_valid = ($urandom_range(0, 9) < 8);
    s.stall    = ($urandom_range(0, 9) < 2);
    s.flush    = ($urandom_range(0, 19) == 0);
    s.va       = ($urandom_range(0, 9) < 8);
    s.vb       = ($urandom_range(0, 9) < 8);
    s.srca     = 1'($urandom_range(0, 1));
    s.srcb     = 1'($urandom_range(0, 1));
    s.rwa      = ($urandom_range(0, 9) < 8);
    s.rwb      = 1'($urandom_range(0, 1));
    s.ca       = 4'($urandom);
    s.cb       = 4'($urandom);
    s.rd1a     = $urandom;
    s.rd2a     = $urandom;
    s.rd1b     = $urandom;
    s.rd2b     = $urandom;
    s.imma     = $urandom;
    s.immb     = $urandom;
    s.alu      = $urandom;
    s.rs1b     = 5'($urandom_range(0, 3));
    s.rs2b     = 5'($urandom_range(0, 3));
    s.rda      = 5'($urandom_range(0, 3));
    s.rdb      = 5'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.InValid_i    = s.in_valid;
    bus.Stall_i      = s.stall;
    bus.Flush_i      = s.flush;
    bus.ValidA_i     = s.va;
    bus.ValidB_i     = s.vb;
    bus.ALUCtrlA_i   = s.ca;
    bus.ALUCtrlB_i   = s.cb;
    bus.ALUSrcBA_i   = s.srca;
    bus.ALUSrcBB_i   = s.srcb;
    bus.RD1A_i       = s.rd1a;
    bus.RD2A_i       = s.rd2a;
    bus.RD1B_i       = s.rd1b;
    bus.RD2B_i       = s.rd2b;
    bus.ImmExtA_i    = s.imma;
    bus.ImmExtB_i    = s.immb;
    bus.Rs1B_i       = s.rs1b;
    bus.Rs2B_i       = s.rs2b;
    bus.RdA_i        = s.rda;
    bus.RdB_i        = s.rdb;
    bus.RegWriteA_i  = s.rwa;
    bus.RegWriteB_i  = s.rwb;
    bus.ALUResultA_i = s.alu;
  endtask

  // Reference: a pair either goes through whole, or A goes now and the
  // dependent B waits in parked_q for the next unstalled edge.
  task automatic step(input stim_t s);
    stim_t p;
    logic  dep;
    @(negedge clk);
    apply(s);
    #1;
    chk("InReady", {31'd0, bus.InReady_o}, {31'd0, !s.stall && parked_q.size() == 0});
    if (s.flush) begin
      cur.va = 0; cur.vb = 0; cur.rwa = 0; cur.rwb = 0;
      cur.chk_a = 0; cur.chk_b = 0;
      parked_q.delete();
    end else if (!s.stall) begin
      if (parked_q.size() > 0) begin
        p = parked_q.pop_front();
        cur.va = 0; cur.rwa = 0; cur.chk_a = 0;
        cur.vb = 1; cur.rwb = p.rwb; cur.cb = p.cb; cur.srcb = p.srcb;
        cur.rd1b = (p.rs1b == p.rda) ? s.alu : p.rd1b;
        cur.rd2b = (!p.srcb && p.rs2b == p.rda) ? s.alu : p.rd2b;
        cur.immb = p.immb; cur.rdb = p.rdb; cur.chk_b = 1;
      end else if (s.in_valid) begin
        dep = s.va && s.vb && s.rwa && (s.rda != 0) &&
              ((s.rs1b == s.rda) || (!s.srcb && s.rs2b == s.rda));
        cur.va = s.va; cur.rwa = s.rwa; cur.ca = s.ca; cur.srca = s.srca;
        cur.rd1a = s.rd1a; cur.rd2a = s.rd2a; cur.imma = s.imma; cur.rda = s.rda;
        cur.chk_a = 1; cur.chk_b = 1;
        if (dep) begin
          cur.vb = 0; cur.rwb = 0; cur.cb = 0; cur.srcb = 0;
          cur.rd1b = 0; cur.rd2b = 0; cur.immb = 0; cur.rdb = 0;
          parked_q.push_back(s);
          cur.splits = cur.splits + 1;
        end else begin
          cur.vb = s.vb; cur.rwb = s.rwb; cur.cb = s.cb; cur.srcb = s.srcb;
          cur.rd1b = s.rd1b; cur.rd2b = s.rd2b; cur.immb = s.immb; cur.rdb = s.rdb;
        end
      end else begin
        cur.va = 0; cur.vb = 0; cur.rwa = 0; cur.rwb = 0;
        cur.chk_a = 0; cur.chk_b = 0;
      end
    end
    exp_q.push_back(cur);
    @(posedge clk);
  endtask

  // monitor: every registered update is compared against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ValidA", {31'd0, bus.ValidA_o}, {31'd0, e.va});
        chk("ValidB", {31'd0, bus.ValidB_o}, {31'd0, e.vb});
        chk("RegWriteA", {31'd0, bus.RegWriteA_o}, {31'd0, e.rwa});
        chk("RegWriteB", {31'd0, bus.RegWriteB_o}, {31'd0, e.rwb});
        if (e.chk_a) begin
          chk("ALUCtrlA", {28'd0, bus.ALUCtrlA_o}, {28'd0, e.ca});
          chk("ALUSrcBA", {31'd0, bus.ALUSrcBA_o}, {31'd0, e.srca});
          chk("RD1A", bus.RD1A_o, e.rd1a);
          chk("RD2A", bus.RD2A_o, e.rd2a);
          chk("ImmExtA", bus.ImmExtA_o, e.imma);
          chk("RdA", {27'd0, bus.RdA_o}, {27'd0, e.rda});
        end
        if (e.chk_b) begin
          chk("ALUCtrlB", {28'd0, bus.ALUCtrlB_o}, {28'd0, e.cb});
          chk("ALUSrcBB", {31'd0, bus.ALUSrcBB_o}, {31'd0, e.srcb});
          chk("RD1B", bus.RD1B_o, e.rd1b);
          chk("RD2B", bus.RD2B_o, e.rd2b);
          chk("ImmExtB", bus.ImmExtB_o, e.immb);
          chk("RdB", {27'd0, bus.RdB_o}, {27'd0, e.rdb});
        end
`ifdef ID_EX_SPLIT_CNT_EN
        chk("SplitCount", bus.SplitCount_o, e.splits);
`endif
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ValidA"}, {31'd0, bus.ValidA_o}, 32'd0);
    chk({tag, "_ValidB"}, {31'd0, bus.ValidB_o}, 32'd0);
    chk({tag, "_RegWriteA"}, {31'd0, bus.RegWriteA_o}, 32'd0);
    chk({tag, "_RegWriteB"}, {31'd0, bus.RegWriteB_o}, 32'd0);
    chk({tag, "_RD1A"}, bus.RD1A_o, 32'd0);
    chk({tag, "_RD1B"}, bus.RD1B_o, 32'd0);
    chk({tag, "_ImmExtB"}, bus.ImmExtB_o, 32'd0);
    chk({tag, "_InReady"}, {31'd0, bus.InReady_o}, 32'd0);
`ifdef ID_EX_SPLIT_CNT_EN
    chk({tag, "_SplitCount"}, bus.SplitCount_o, 32'd0);
`endif
  endtask

  function automatic stim_t indep_pair();
    stim_t s;
    s = blank();
    s.in_valid = 1; s.va = 1; s.vb = 1; s.rwa = 1; s.rwb = 1;
    s.rda = 5; s.rd1a = 3; s.rd2a = 4; s.ca = 4'h2;
    s.rdb = 6; s.rs1b = 7; s.rs2b = 8; s.rd1b = 32'h11; s.rd2b = 32'h22; s.cb = 4'h2;
    return s;
  endfunction

  function automatic stim_t dep_pair();
    stim_t s;
    s = indep_pair();
    s.rs1b = 5; s.rd1b = 32'hDEAD;
    return s;
  endfunction

  initial begin : stimulus
    stim_t s;
    rst_n = 1'b0;
    cur   = '0;
    apply(blank());
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    step(indep_pair());
    step(indep_pair());

    // asynchronous reset mid-stream while outputs are live
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cur = '0;
    parked_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(indep_pair());

    // split, with A's result arriving in the next cycle
    step(dep_pair());
    s = blank(); s.in_valid = 1; s.alu = 7;
    step(s);

    // immediate-operand B reading RdA through Rs2 only: no split
    s = indep_pair(); s.srcb = 1; s.rs2b = 5; s.rs1b = 3;
    step(s);

    // x0 destination never splits, invalid B never splits
    s = dep_pair(); s.rda = 0; s.rs1b = 0;
    step(s);
    s = dep_pair(); s.vb = 0;
    step(s);

    // stall two cycles during SPLIT, then release with a new A result
    step(dep_pair());
    s = blank(); s.stall = 1; s.alu = 32'hBAD0;
    step(s);
    step(s);
    s = blank(); s.alu = 32'h1234;
    step(s);

    // flush together with stall during SPLIT drops the parked B
    step(dep_pair());
    s = blank(); s.stall = 1; s.flush = 1; s.alu = 32'h5555;
    step(s);
    s = blank(); s.alu = 32'h6666;
    step(s);
    step(s);

    for (int i = 0; i < 2000; i++) begin
      step(rand_stim());
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_dual_reg.md
Name: id_ex_dual_reg

Overview:
- Dual-issue pipeline register between decode and the two-slot execute stage (slots A and B); holds each slot's ALU control, operands and immediates for one cycle.
- Detects an intra-pair RAW hazard (slot B reads slot A's destination). On a hazard it splits the pair: issues A alone, then issues B one cycle later with the dependent operand replaced by A's ALU result, fed back from execute.
- Supports stall (hold) and flush (bubble) requests from the hazard unit.

Parameters:
- DATA_WIDTH, 32, operand and result width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- InValid_i  input  1  decode presents a pair this cycle
- InReady_o  output  1  stage accepts the pair at this edge
- Stall_i  input  1  hold all output registers
- Flush_i  input  1  invalidate outputs and any held slot-B instruction
- ValidA_i / ValidB_i  input  1  slot occupied
- ALUCtrlA_i / ALUCtrlB_i  input  4  ALU control
- ALUSrcBA_i / ALUSrcBB_i  input  1  immediate select for operand 2
- RD1A_i, RD2A_i, RD1B_i, RD2B_i  input  DATA_WIDTH  register-file read data
- ImmExtA_i / ImmExtB_i  input  DATA_WIDTH  extended immediate
- Rs1B_i, Rs2B_i, RdA_i, RdB_i  input  REG_ADDR_WIDTH  register indices
- RegWriteA_i / RegWriteB_i  input  1  slot writes the register file
- ALUResultA_i  input  DATA_WIDTH  execute slot-A result (combinational feedback)
- ValidA_o, ValidB_o, ALUCtrlA_o, ALUCtrlB_o, ALUSrcBA_o, ALUSrcBB_o, RD1A_o, RD2A_o, RD1B_o, RD2B_o, ImmExtA_o, ImmExtB_o, RdA_o, RdB_o, RegWriteA_o, RegWriteB_o  output  (matching widths)  registered execute-side copies

Behaviour:
- Reset (rst_n=0, asynchronous): every output register is 0, FSM goes to NORMAL, hold buffer is cleared, InReady_o=0 while reset is asserted.
- Hazard (combinational on inputs): ValidA_i & ValidB_i & RegWriteA_i & RdA_i!=0 & (Rs1B_i==RdA_i | (!ALUSrcBB_i & Rs2B_i==RdA_i)). Record the two match flags as Fwd1 and Fwd2.
- InReady_o = !Stall_i & state==NORMAL.
- Accepted pair = InValid_i & InReady_o, sampled at the clock edge.

FSM:
- NORMAL, accepted pair, no hazard: both slots load to outputs; latency is 1 cycle.
- NORMAL, accepted pair, hazard: slot A loads. ValidB_o=0 and all other B outputs are 0. Slot B fields plus Fwd1/Fwd2 are captured into the hold buffer. Go to SPLIT.
- NORMAL, no accepted pair and !Stall_i: load a bubble (all Valid/RegWrite outputs 0).
- SPLIT, !Stall_i: ValidA_o=0; the held B is issued on slot B. RD1B_o = Fwd1 ? ALUResultA_i : held RD1; RD2B_o likewise with Fwd2. Go to NORMAL. ALUResultA_i is the result of the A instruction currently in execute.
- Stall_i (no flush): all output registers, hold buffer and state hold. No input is accepted.

Priority and boundary cases:
- Flush_i overrides Stall_i. On flush: Valid and RegWrite outputs go to 0, hold buffer is discarded, state goes to NORMAL, input is not accepted that edge.
- An invalid slot never counts as a hazard source or sink. ValidB_i=0 with ValidA_i=1 issues A alone, no split.
- RdA_i==0 never triggers a split (x0 writes are discarded).
- Data fields of invalid slots are don't-care, but they are registered deterministically, not left X.
- Loads never reach this stage paired with a dependent slot B; decode guarantees this. The patch uses ALU results only.

Optional Feature:
- Macro: ID_EX_SPLIT_CNT_EN.
- Defined: adds output SplitCount_o, 32 bits. It resets to 0 and increments by 1 on each NORMAL→SPLIT transition. It wraps from 0xFFFFFFFF to 0 and is not affected by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-stream with valid outputs → all outputs 0 immediately (asynchronously); first accepted pair after release appears 1 cycle later.
- Independent pair: A: x5=x1+x2 (RD1A=3, RD2A=4); B: x6=x7+x8 → both Valid outputs 1 next cycle, operands unchanged, InReady_o stays 1.
- Split: A: RdA=5, RegWriteA=1; B: Rs1B=5 with held RD1B=0xDEAD. Drive ALUResultA_i=7 during the A-in-execute cycle → cycle 1: ValidA_o=1, ValidB_o=0, InReady_o=0; cycle 2: ValidB_o=1, RD1B_o=7, ValidA_o=0.
- Immediate B: ALUSrcBB=1, Rs2B=RdA=5, Rs1B≠5 → no split.
- Stall during SPLIT for 2 cycles, then release → B issues with the ALUResultA_i present at the release edge; outputs frozen during the stall.
- Flush during SPLIT with Stall_i=1 simultaneously → ValidA_o=ValidB_o=0 next cycle, held B is never issued. With ID_EX_SPLIT_CNT_EN defined, SplitCount_o=1.
